// File: rtl/wshb_pkg.sv
// Shared Wishbone definitions for the SDRAM port arbiter: default widths,
// cycle-type codes and the arbiter state type.
package wshb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Width of an index into n masters (never below one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wshb_arbiter_if.sv
// Bundle of the per-master request side and the shared slave side of the
// SDRAM Wishbone arbiter.
interface wshb_arbiter_if
  import wshb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int AW        = WB_AW,
  parameter int DW        = WB_DW
) ();

  logic [N_MASTERS-1:0]        m_cyc;
  logic [N_MASTERS-1:0]        m_stb;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS*AW-1:0]     m_adr;
  logic [N_MASTERS*DW/8-1:0]   m_sel;
  logic [N_MASTERS*DW-1:0]     m_dat_ms;
  logic [N_MASTERS*3-1:0]      m_cti;
  logic [N_MASTERS*2-1:0]      m_bte;
  logic [N_MASTERS-1:0]        m_ack;
  logic [DW-1:0]               m_dat_sm;

  logic                        s_cyc;
  logic                        s_stb;
  logic                        s_we;
  logic [AW-1:0]               s_adr;
  logic [DW/8-1:0]             s_sel;
  logic [DW-1:0]               s_dat_ms;
  logic [2:0]                  s_cti;
  logic [1:0]                  s_bte;
  logic                        s_ack;
  logic [DW-1:0]               s_dat_sm;

  // Arbiter view: slave to the masters, master towards the SDRAM controller.
  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_ms, m_cti, m_bte,
    output m_ack, m_dat_sm,
    output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_ms, s_cti, s_bte,
    input  s_ack, s_dat_sm
  );

  // Environment view: the requesting masters plus the SDRAM slave.
  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_ms, m_cti, m_bte,
    input  m_ack, m_dat_sm,
    input  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_ms, s_cti, s_bte,
    output s_ack, s_dat_sm
  );

endinterface

// File: rtl/wshb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx,
// scanning upwards modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx
);

  logic [IW:0]   pos_raw [N];
  logic [IW-1:0] pos     [N];
  logic [IW-1:0] acc     [N];
  logic [N-1:0]  rreq;
  logic [N-1:0]  first;

  // Slot gd holds the master at distance gd+1 from last_idx.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      assign pos_raw[gi] = {1'b0, last_idx} + (IW+1)'(gi + 1);
      assign pos[gi]     = (pos_raw[gi] >= (IW+1)'(N)) ? IW'(pos_raw[gi] - (IW+1)'(N))
                                                       : pos_raw[gi][IW-1:0];
      assign rreq[gi]    = req[pos[gi]];
      if (gi == 0) begin : g_head
        assign first[gi] = rreq[gi];
        assign acc[gi]   = rreq[gi] ? pos[gi] : '0;
      end else begin : g_tail
        assign first[gi] = rreq[gi] & ~(|rreq[gi-1:0]);
        assign acc[gi]   = acc[gi-1] | (first[gi] ? pos[gi] : '0);
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign winner[gi] = (|req) && (winner_idx == IW'(gi));
    end
  endgenerate

  assign winner_idx = acc[N-1];

endmodule

// File: rtl/wshb_arbiter.sv
// Round-robin arbiter sharing the SDRAM Wishbone slave between N masters,
// with an optional acked-transfer cap per grant when others are waiting.
module wshb_arbiter
  import wshb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int MAX_ACKS  = 64,
  parameter int AW        = WB_AW,
  parameter int DW        = WB_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wshb_arbiter_if.slave        bus,
  output logic [N_MASTERS-1:0] grant
);

  localparam int IW = idx_width(N_MASTERS);
  localparam int SW = DW / 8;
  localparam int CW = (MAX_ACKS > 0) ? $clog2(MAX_ACKS + 1) : 1;

  arb_state_t           state_reg, state_next;
  logic [N_MASTERS-1:0] grant_reg, grant_next;
  logic [IW-1:0]        last_idx_reg, last_idx_next;
  logic [CW-1:0]        ack_cnt_reg, ack_cnt_next;

  logic [N_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]        pick_idx;

  logic [AW-1:0] adr_arr [N_MASTERS];
  logic [SW-1:0] sel_arr [N_MASTERS];
  logic [DW-1:0] dat_arr [N_MASTERS];
  logic [2:0]    cti_arr [N_MASTERS];
  logic [1:0]    bte_arr [N_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
      assign adr_arr[gi] = bus.m_adr[gi*AW +: AW];
      assign sel_arr[gi] = bus.m_sel[gi*SW +: SW];
      assign dat_arr[gi] = bus.m_dat_ms[gi*DW +: DW];
      assign cti_arr[gi] = bus.m_cti[gi*3 +: 3];
      assign bte_arr[gi] = bus.m_bte[gi*2 +: 2];
    end
  endgenerate

  rr_pick #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_pick (
    .req        (bus.m_cyc),
    .last_idx   (last_idx_reg),
    .winner     (pick_onehot),
    .winner_idx (pick_idx)
  );

  // While granted, last_idx_reg is the index of the owning master.
  logic g_cyc, g_stb, ack_evt, others_req, cnt_last;
  assign g_cyc      = bus.m_cyc[last_idx_reg];
  assign g_stb      = bus.m_stb[last_idx_reg];
  assign ack_evt    = (state_reg == GRANT) && bus.s_ack && g_stb;
  assign others_req = |(bus.m_cyc & ~grant_reg);
  assign cnt_last   = (MAX_ACKS != 0) && (int'(ack_cnt_reg) >= MAX_ACKS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      last_idx_reg <= IW'(N_MASTERS - 1);
      ack_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      last_idx_reg <= last_idx_next;
      ack_cnt_reg  <= ack_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_idx_next = last_idx_reg;
    ack_cnt_next  = ack_cnt_reg;
    bus.s_cyc     = 1'b0;
    bus.s_stb     = 1'b0;
    bus.s_we      = 1'b0;
    bus.s_adr     = '0;
    bus.s_sel     = '0;
    bus.s_dat_ms  = '0;
    bus.s_cti     = '0;
    bus.s_bte     = '0;
    bus.m_ack     = '0;
    bus.m_dat_sm  = bus.s_dat_sm;

    case (state_reg)
      IDLE: begin
        if (|bus.m_cyc) begin
          state_next    = GRANT;
          grant_next    = pick_onehot;
          last_idx_next = pick_idx;
          ack_cnt_next  = '0;
        end
      end
      GRANT: begin
        bus.s_cyc    = g_cyc;
        bus.s_stb    = g_stb;
        bus.s_we     = bus.m_we[last_idx_reg];
        bus.s_adr    = adr_arr[last_idx_reg];
        bus.s_sel    = sel_arr[last_idx_reg];
        bus.s_dat_ms = dat_arr[last_idx_reg];
        bus.s_cti    = cti_arr[last_idx_reg];
        bus.s_bte    = bte_arr[last_idx_reg];
        bus.m_ack    = grant_reg & {N_MASTERS{ack_evt}};
        if (ack_evt && (int'(ack_cnt_reg) < MAX_ACKS)) begin
          ack_cnt_next = ack_cnt_reg + 1'b1;
        end
        // Pre-emption only on an ack edge, so no transfer is ever cut short.
        if (!g_cyc || (ack_evt && cnt_last && others_req)) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant = grant_reg;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Randomized bench for wshb_arbiter against an ownership/round-robin model.
module tb_wshb_arbiter;
  import wshb_pkg::*;

  localparam int N    = 3;
  localparam int MAXA = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] grant;

  always #5 clk = ~clk;

  wshb_arbiter_if #(.N_MASTERS(N), .AW(AW), .DW(DW)) bus ();

  wshb_arbiter #(
    .N_MASTERS (N),
    .MAX_ACKS  (MAXA),
    .AW        (AW),
    .DW        (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .grant (grant)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int n_preempt = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Master and slave behaviour
  bit            act   [N];
  bit            stb   [N];
  bit            acked [N];
  bit            done  [N];
  int            rem   [N];
  logic [AW-1:0] adr   [N];
  logic [DW-1:0] dat   [N];
  logic          we    [N];
  logic [SW-1:0] sel   [N];
  logic [2:0]    cti   [N];
  logic [1:0]    bte   [N];
  logic          sack;
  logic [DW-1:0] sdat;

  // Reference model: who owns the slave, who was served last, acks this grant
  int owner = -1;
  int last  = N - 1;
  int cnt   = 0;

  task automatic apply_bus();
    logic [N-1:0]    cyc_v, stb_v, we_v;
    logic [N*AW-1:0] adr_v;
    logic [N*SW-1:0] sel_v;
    logic [N*DW-1:0] dat_v;
    logic [N*3-1:0]  cti_v;
    logic [N*2-1:0]  bte_v;
    for (int i = 0; i < N; i++) begin
      cyc_v[i]            = act[i];
      stb_v[i]            = stb[i];
      we_v[i]             = we[i];
      adr_v[i*AW +: AW]   = adr[i];
      sel_v[i*SW +: SW]   = sel[i];
      dat_v[i*DW +: DW]   = dat[i];
      cti_v[i*3 +: 3]     = cti[i];
      bte_v[i*2 +: 2]     = bte[i];
    end
    bus.m_cyc    = cyc_v;
    bus.m_stb    = stb_v;
    bus.m_we     = we_v;
    bus.m_adr    = adr_v;
    bus.m_sel    = sel_v;
    bus.m_dat_ms = dat_v;
    bus.m_cti    = cti_v;
    bus.m_bte    = bte_v;
    bus.s_ack    = sack;
    bus.s_dat_sm = sdat;
  endtask

  task automatic drive(input int mask, input int req_pct, input int ack_pct, input int maxlen);
    for (int i = 0; i < N; i++) begin
      done[i] = 1'b0;
      if (act[i] && acked[i]) begin
        rem[i]--;
        adr[i] = adr[i] + 32'd4;
        dat[i] = $urandom;
        if (rem[i] == 0) begin
          act[i]  = 1'b0;
          done[i] = 1'b1;
        end
      end
      if (!act[i] && !done[i] && (((mask >> i) & 1) == 1) && ($urandom_range(99) < req_pct)) begin
        act[i] = 1'b1;
        rem[i] = $urandom_range(maxlen, 1);
        adr[i] = $urandom & 32'hFFFF_FFFC;
        dat[i] = $urandom;
        we[i]  = 1'($urandom_range(1));
        sel[i] = 4'($urandom_range(15, 1));
        cti[i] = ($urandom_range(1) == 1) ? CTI_EOB : CTI_CLASSIC;
        bte[i] = BTE_LINEAR;
        stb[i] = 1'b0;
      end
      // A raised stb is held, with its fields, until acked.
      if (!act[i]) stb[i] = 1'b0;
      else if (!stb[i] || acked[i]) stb[i] = ($urandom_range(7) != 0);
      acked[i] = 1'b0;
    end
    sack = ($urandom_range(99) < ack_pct);
    sdat = $urandom;
    apply_bus();
  endtask

  task automatic eval_cycle();
    logic [N-1:0] e_grant, e_ack;
    logic [75:0]  e_s, o_s;
    bit           ack, others, found;
    int           c;
    e_grant = '0;
    e_ack   = '0;
    e_s     = '0;
    ack     = 1'b0;
    if (owner >= 0) begin
      e_grant[owner] = 1'b1;
      ack            = sack && stb[owner];
      e_ack[owner]   = ack;
      e_s = {act[owner], stb[owner], we[owner], adr[owner], sel[owner],
             dat[owner], cti[owner], bte[owner]};
    end
    o_s = {bus.s_cyc, bus.s_stb, bus.s_we, bus.s_adr, bus.s_sel,
           bus.s_dat_ms, bus.s_cti, bus.s_bte};
    check_eq("grant", grant, e_grant);
    check_eq("m_ack", bus.m_ack, e_ack);
    check_eq("s_bus", o_s, e_s);
    check_eq("m_dat_sm", bus.m_dat_sm, sdat);
    for (int i = 0; i < N; i++) begin
      if (e_ack[i]) begin
        acked[i] = 1'b1;
        $display("xfer m%0d %s adr=%08h data=%08h", i, we[i] ? "WR" : "RD",
                 adr[i], we[i] ? dat[i] : sdat);
      end
    end
    if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (last + k) % N;
        if (!found && act[c]) begin
          found = 1'b1;
          owner = c;
        end
      end
      if (found) begin
        last = owner;
        cnt  = 0;
      end
    end else if (!act[owner]) begin
      owner = -1;
    end else if (ack) begin
      cnt    = (cnt + 1 < MAXA) ? cnt + 1 : MAXA;
      others = 1'b0;
      for (int j = 0; j < N; j++) if (j != owner && act[j]) others = 1'b1;
      if (MAXA != 0 && cnt == MAXA && others) begin
        owner = -1;
        n_preempt++;
      end
    end
  endtask

  task automatic run(input int cycles, input int mask, input int req_pct,
                     input int ack_pct, input int maxlen);
    repeat (cycles) begin
      drive(mask, req_pct, ack_pct, maxlen);
      @(negedge clk);
      eval_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  int ph_len  [5] = '{400, 600, 500, 500, 400};
  int ph_mask [5] = '{2, 7, 3, 5, 7};
  int ph_req  [5] = '{100, 60, 40, 90, 100};
  int ph_ack  [5] = '{100, 70, 35, 100, 50};
  int ph_max  [5] = '{100, 12, 6, 20, 3};

  initial begin
    logic [N-1:0] e_pre;
    int guard;
    // Hold every master requesting with the slave acking while in reset.
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b1; stb[i] = 1'b1; acked[i] = 1'b0; rem[i] = 0;
      adr[i] = 32'h1000 * (i + 1); dat[i] = $urandom; we[i] = 1'b1;
      sel[i] = 4'hF; cti[i] = CTI_CLASSIC; bte[i] = BTE_LINEAR;
    end
    sack = 1'b1;
    sdat = 32'hDEAD_BEEF;
    apply_bus();
    #1 rst_n = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check_eq("rst_s_cyc", bus.s_cyc, 0);
      check_eq("rst_s_stb", bus.s_stb, 0);
      check_eq("rst_grant", grant, 0);
      check_eq("rst_m_ack", bus.m_ack, 0);
    end
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; stb[i] = 1'b0;
    end
    apply_bus();
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int p = 0; p < 5; p++) begin
      run(ph_len[p], ph_mask[p], ph_req[p], ph_ack[p], ph_max[p]);
    end

    // Reset in the middle of an active, acked strobe.
    guard = 0;
    while (!(owner >= 0 && act[owner] && stb[owner]) && guard < 100) begin
      run(1, 7, 100, 50, 20);
      guard++;
    end
    sack = 1'b1;
    apply_bus();
    e_pre = '0;
    if (owner >= 0) e_pre[owner] = 1'b1;
    #1;
    check_eq("pre_rst_s_cyc", bus.s_cyc, 1);
    check_eq("pre_rst_m_ack", bus.m_ack, e_pre);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_s_cyc", bus.s_cyc, 0);
    check_eq("mid_rst_s_stb", bus.s_stb, 0);
    check_eq("mid_rst_grant", grant, 0);
    check_eq("mid_rst_m_ack", bus.m_ack, 0);
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; stb[i] = 1'b0; acked[i] = 1'b0;
    end
    owner = -1;
    last  = N - 1;
    cnt   = 0;
    apply_bus();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(1, 7, 100, 100, 10);
    check_eq("rst_first_win", grant, 3'b001);
    run(300, 7, 80, 60, 8);

    $display("info: %0d pre-emptions exercised", n_preempt);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
